demux14_double_slice: RTL and testbench

- 1-to-4 demultiplexer for 2-bit data; the distributing counterpart of the 4-to-1 two-bit selector on the Nvboard datapath.
- One input stream (data plus 2-bit channel select) is steered into one of four registered output slots.
- Valid/ready handshake on the input and on each output.
- Per-channel delivered-transfer counters, so NVBoard LEDs and segment displays can show traffic.

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_slot.sv | 41 ++++
 rtl/demux14_double_slice.sv | 51 +++++
 tb/tb_demux14_double_slice.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 two-bit demultiplexer slice.
package demux_pkg;
    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 2;
    localparam int DEF_CNT_W = 8;

    typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/demux_slot.sv
// One output register slice: data word, valid flag and delivered-transfer counter.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt,
    output logic             slot_ready
);
    logic drain;

    assign drain      = valid && out_ready;
    assign slot_ready = !valid || out_ready;

    // A load in the same cycle as a drain keeps valid high: full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else begin
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
            if (drain) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux14_double_slice.sv
// 1-to-4 demultiplexer: steers a valid/ready input stream into four registered slots.
module demux14_double_slice
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat,
    output logic                    busy
);
    logic [NUM_CH-1:0] slot_ready;
    logic [NUM_CH-1:0] load;
    ch_idx_t           sel;

    assign sel = in_sel;

    // Ready depends only on the addressed slot, never on in_valid.
    assign in_ready = slot_ready[sel];
    assign busy     = |out_valid;

    always_comb begin
        load = '0;
        load[sel] = in_valid && in_ready;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .data      (out_data[i*WIDTH +: WIDTH]),
            .valid     (out_valid[i]),
            .cnt       (cnt_flat[i*CNT_W +: CNT_W]),
            .slot_ready(slot_ready[i])
        );
    end
endmodule

// File: tb/tb_demux14_double_slice.sv
// Bench for demux14_double_slice: directed scenarios plus random traffic against a slot-array model.
module tb_demux14_double_slice;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] cnt_flat;
    logic        busy;

    int n_chk = 0;
    int n_pass = 0;

    logic [1:0] m_data [4];
    bit         m_valid[4];
    int         m_cnt  [4];

    demux14_double_slice dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_flat(cnt_flat),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0; m_valid[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0]  ed;
        logic [3:0]  ev;
        logic [31:0] ec;
        for (int i = 0; i < 4; i++) begin
            ed[i*2 +: 2] = m_data[i];
            ev[i]        = m_valid[i];
            ec[i*8 +: 8] = m_cnt[i][7:0];
        end
        check({tag, ".valid"}, out_valid, ev);
        check({tag, ".data"}, out_data, ed);
        check({tag, ".cnt"}, cnt_flat, ec);
        check({tag, ".busy"}, busy, |ev);
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
    task automatic cycle(input bit v, input logic [1:0] s, input logic [1:0] d,
                         input logic [3:0] rdy, input string tag);
        bit exp_rdy;
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; out_ready = rdy;
        #1;
        exp_rdy = !m_valid[s] || rdy[s];
        check({tag, ".in_ready"}, in_ready, exp_rdy);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bit drain;
            drain = m_valid[i] && rdy[i];
            if (drain) m_cnt[i] = (m_cnt[i] + 1) % 256;
            if (v && exp_rdy && s == i) begin
                m_valid[i] = 1; m_data[i] = d;
            end else if (drain) begin
                m_valid[i] = 0;
            end
        end
        compare_all(tag);
    endtask

    task automatic reset_now(input string tag);
        @(negedge clk);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        model_clear();
        check({tag, ".rst_valid"}, out_valid, 4'b0000);
        check({tag, ".rst_cnt"}, cnt_flat, 32'h0);
        check({tag, ".rst_busy"}, busy, 1'b0);
        check({tag, ".rst_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1; in_sel = 2'd1; in_data = 2'b11;
        @(posedge clk);
        #1 check({tag, ".no_accept_in_reset"}, out_valid, 4'b0000);
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
    endtask

    initial begin
        bit         hv;
        logic [1:0] hs, hd;
        logic [3:0] hr;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // All slots full, then asynchronous reset mid-cycle.
        for (int i = 0; i < 4; i++) cycle(1, 2'(i), 2'(3 - i), 4'b0000, "fill");
        check("fill.valid_all", out_valid, 4'b1111);
        reset_now("reset1");

        // Single transfer on channel 2.
        cycle(1, 2'd2, 2'b11, 4'b0000, "single");
        check("single.valid", out_valid, 4'b0100);
        check("single.data2", out_data[5:4], 2'b11);
        @(negedge clk); in_valid = 0; in_sel = 2'd2; #1;
        check("single.ready_sel2", in_ready, 1'b0);
        in_sel = 2'd0; #1;
        check("single.ready_sel0", in_ready, 1'b1);
        cycle(0, 2'd0, 2'b00, 4'b0100, "single_drain");
        check("single.valid2_clr", out_valid[2], 1'b0);
        check("single.cnt2", cnt_flat[23:16], 8'd1);

        // Back-to-back throughput.
        reset_now("reset2");
        cycle(1, 2'd0, 2'd0, 4'b1111, "b2b0");
        cycle(1, 2'd1, 2'd1, 4'b1111, "b2b1");
        cycle(1, 2'd2, 2'd2, 4'b1111, "b2b2");
        cycle(1, 2'd3, 2'd3, 4'b1111, "b2b3");
        cycle(1, 2'd0, 2'd1, 4'b1111, "b2b4");
        cycle(0, 2'd0, 2'd0, 4'b1111, "b2b_idle");
        check("b2b.cnt", cnt_flat, {8'd1, 8'd1, 8'd1, 8'd2});

        // Simultaneous drain and load on channel 1.
        cycle(1, 2'd1, 2'b01, 4'b0000, "sdl_fill");
        cycle(1, 2'd1, 2'b10, 4'b0010, "sdl");
        check("sdl.valid1", out_valid[1], 1'b1);
        check("sdl.data1", out_data[3:2], 2'b10);
        check("sdl.cnt1", cnt_flat[15:8], 8'd2);
        cycle(0, 2'd0, 2'd0, 4'b0010, "sdl_drain");

        // Blocked channel 3 must not block channel 0.
        cycle(1, 2'd3, 2'b10, 4'b0000, "blk_fill");
        for (int k = 0; k < 5; k++) begin
            cycle(1, 2'd3, 2'b01, 4'b0000, "blk_hold");
            check("blk.data3", out_data[7:6], 2'b10);
        end
        cycle(1, 2'd0, 2'b11, 4'b0000, "blk_other");
        check("blk.valid0", out_valid[0], 1'b1);
        check("blk.data0", out_data[1:0], 2'b11);

        // Random traffic; source holds its word while stalled.
        hv = 0; hs = 0; hd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!(hv && m_valid[hs] && !out_ready[hs])) begin
                hv = 1'($urandom_range(0, 3) != 0);
                hs = 2'($urandom);
                hd = 2'($urandom);
            end
            hr = 4'($urandom);
            cycle(hv, hs, hd, hr, "rand");
        end

        // Counter wrap on channel 0.
        reset_now("reset3");
        for (int k = 0; k < 256; k++) cycle(1, 2'd0, 2'($urandom), 4'b0001, "wrap");
        check("wrap.cnt0_255", cnt_flat[7:0], 8'd255);
        cycle(0, 2'd0, 2'd0, 4'b0001, "wrap_last");
        check("wrap.cnt0_0", cnt_flat[7:0], 8'd0);
        check("wrap.others", cnt_flat[31:8], 24'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
